// File: rtl/project_switch_ctrl_if.sv
// Wishbone slave bus bundle for project_switch_ctrl.
interface project_switch_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/project_switch_ctrl.sv
// Wishbone-controlled pad switch: isolate -> switch -> hold sequencing between projects.
// Timed rotation across projects (period register at ADDR_CTRL+8) is built when AUTO_ROTATE_EN is defined.
module project_switch_ctrl #(
    parameter logic [31:0] ADDR_CTRL    = 32'h3000_0010,
    parameter logic [31:0] ADDR_STATUS  = 32'h3000_0014,
    parameter int          NUM_PROJECTS = 3,
    parameter int          GUARD_CYCLES = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    project_switch_ctrl_if.slave    wbs,
    output logic [7:0]              active_project_o,
    output logic [NUM_PROJECTS-1:0] project_reset_o,
    output logic                    io_gate_o,
    output logic                    busy_o
);
    typedef enum logic [1:0] {IDLE, ISOLATE, SWITCH, HOLD} state_t;

    localparam logic [7:0]              GUARD_LAST = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0]              NUM_P      = 8'(NUM_PROJECTS);
    localparam logic [NUM_PROJECTS-1:0] ONE_HOT0   = NUM_PROJECTS'(1);

    state_t      state_q, state_d;
    logic [7:0]  guard_q, guard_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  active_q, active_d;
    logic [7:0]  pend_tgt_q, pend_tgt_d;
    logic        pend_vld_q, pend_vld_d;
    logic        err_q, err_d;
    logic        ack_q;
    logic [31:0] rdata_q, rdata_d;

    logic        hit_ctrl, hit_status, hit_period, valid;
    logic        host_sw, host_ok;
    logic [7:0]  host_tgt, rot_tgt, start_tgt;
    logic        rot_req, start;
    logic [31:0] period_rd;
    logic        unused_bits;

    assign hit_ctrl   = (wbs.wbs_adr_i == ADDR_CTRL);
    assign hit_status = (wbs.wbs_adr_i == ADDR_STATUS);
    assign valid      = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q & (hit_ctrl | hit_status | hit_period);
    assign host_tgt   = wbs.wbs_dat_i[7:0];
    assign host_sw    = valid & wbs.wbs_we_i & hit_ctrl & wbs.wbs_sel_i[0];
    assign host_ok    = host_sw & (host_tgt < NUM_P);
    assign rot_tgt    = (active_q == NUM_P - 8'd1) ? 8'd0 : active_q + 8'd1;
    assign unused_bits = &{1'b0, wbs.wbs_sel_i[3], wbs.wbs_sel_i[1],
                           wbs.wbs_dat_i[31:19], wbs.wbs_dat_i[17:8]};

`ifdef AUTO_ROTATE_EN
    localparam logic [31:0] ADDR_PERIOD = ADDR_CTRL + 32'd8;
    logic [23:0] period_q, rot_cnt_q;
    logic        period_wr;

    assign hit_period = (wbs.wbs_adr_i == ADDR_PERIOD);
    assign period_wr  = valid & wbs.wbs_we_i & hit_period;
    assign period_rd  = {8'd0, period_q};
    // Counter only advances while idle, so time spent switching is not charged to the period.
    assign rot_req    = (state_q == IDLE) && (period_q != 24'd0) &&
                        ({1'b0, rot_cnt_q} + 25'd1 >= {1'b0, period_q});

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            period_q  <= '0;
            rot_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && period_q != 24'd0)
                rot_cnt_q <= rot_req ? 24'd0 : rot_cnt_q + 24'd1;
            for (int b = 0; b < 3; b++)
                if (period_wr && wbs.wbs_sel_i[b])
                    period_q[8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
        end
    end
`else
    assign hit_period = 1'b0;
    assign rot_req    = 1'b0;
    assign period_rd  = '0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        guard_d    = guard_q;
        target_d   = target_q;
        active_d   = active_q;
        pend_tgt_d = pend_tgt_q;
        pend_vld_d = pend_vld_q;
        err_d      = err_q;
        rdata_d    = '0;
        start      = 1'b0;
        start_tgt  = target_q;

        if (valid && !wbs.wbs_we_i)
            rdata_d = hit_ctrl   ? {24'd0, active_q} :
                      hit_status ? {13'd0, err_q, pend_vld_q, state_q != IDLE, pend_tgt_q, active_q} :
                                   period_rd;

        if (host_sw && !host_ok)
            err_d = 1'b1;
        else if (valid && wbs.wbs_we_i && hit_status && wbs.wbs_sel_i[2] && wbs.wbs_dat_i[18])
            err_d = 1'b0;

        // Host writes during a sequence are parked; the newest one replaces any older one.
        if (state_q != IDLE && host_ok) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = host_tgt;
        end

        case (state_q)
            IDLE: begin
                if (host_ok) begin
                    pend_vld_d = 1'b0;
                    start      = (host_tgt != active_q);
                    start_tgt  = host_tgt;
                end else if (pend_vld_q) begin
                    pend_vld_d = 1'b0;
                    start      = (pend_tgt_q != active_q);
                    start_tgt  = pend_tgt_q;
                end else if (rot_req) begin
                    start      = (rot_tgt != active_q);
                    start_tgt  = rot_tgt;
                end
                if (start) begin
                    state_d  = ISOLATE;
                    guard_d  = 8'd0;
                    target_d = start_tgt;
                end
            end
            ISOLATE, HOLD: begin
                if (guard_q == GUARD_LAST) begin
                    guard_d = 8'd0;
                    state_d = (state_q == ISOLATE) ? SWITCH : IDLE;
                end else begin
                    guard_d = guard_q + 8'd1;
                end
            end
            SWITCH: begin
                active_d = target_q;
                state_d  = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q         <= IDLE;
            guard_q         <= '0;
            target_q        <= '0;
            active_q        <= '0;
            pend_tgt_q      <= '0;
            pend_vld_q      <= 1'b0;
            err_q           <= 1'b0;
            ack_q           <= 1'b0;
            rdata_q         <= '0;
            busy_o          <= 1'b0;
            io_gate_o       <= 1'b1;
            project_reset_o <= '1;
        end else begin
            state_q         <= state_d;
            guard_q         <= guard_d;
            target_q        <= target_d;
            active_q        <= active_d;
            pend_tgt_q      <= pend_tgt_d;
            pend_vld_q      <= pend_vld_d;
            err_q           <= err_d;
            ack_q           <= valid;
            rdata_q         <= rdata_d;
            busy_o          <= (state_d != IDLE);
            io_gate_o       <= (state_d != IDLE);
            project_reset_o <= (state_d == IDLE) ? ~(ONE_HOT0 << active_d) : '1;
        end
    end

    assign wbs.wbs_ack_o    = ack_q;
    assign wbs.wbs_dat_o    = rdata_q;
    assign active_project_o = active_q;
endmodule

// File: tb/tb_project_switch_ctrl.sv
// Self-checking bench for project_switch_ctrl: cycle model plus directed scenarios.
module tb_project_switch_ctrl;
    localparam int G = 4;
    localparam int N = 3;
    localparam logic [31:0] A_CTRL = 32'h3000_0010;
    localparam logic [31:0] A_STAT = 32'h3000_0014;
    localparam logic [31:0] A_PER  = 32'h3000_0018;
`ifdef AUTO_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] active;
    logic [2:0] proj_rst;
    logic       gate, busy;
    bit         chk_en = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    project_switch_ctrl_if bus ();

    project_switch_ctrl #(.NUM_PROJECTS(N), .GUARD_CYCLES(G)) dut (
        .wb_clk_i        (clk),
        .wb_rst_n_i      (rst_n),
        .wbs             (bus),
        .active_project_o(active),
        .project_reset_o (proj_rst),
        .io_gate_o       (gate),
        .busy_o          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a switch is a busy window of 2G+1 cycles whose new project appears G+1 cycles in.
    int          m_active, m_target, m_left, m_pend_t, m_idle_cnt;
    bit          m_pend_v, m_err, m_ack, m_in_rst;
    logic [31:0] m_rdata;
    logic [23:0] m_period;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_target = 0; m_left = 0; m_pend_t = 0; m_idle_cnt = 0;
            m_pend_v = 0; m_err = 0; m_ack = 0; m_in_rst = 1; m_rdata = 0; m_period = 0;
        end else begin
            bit acc, host, ok, rot;
            int tgt;
            logic [31:0] a, d;
            a = bus.wbs_adr_i;
            d = bus.wbs_dat_i;
            m_in_rst = 0;
            acc = bus.wbs_cyc_i && bus.wbs_stb_i && !m_ack &&
                  (a == A_CTRL || a == A_STAT || (ROT && a == A_PER));
            m_rdata = 0;
            if (acc && !bus.wbs_we_i) begin
                if (a == A_CTRL)      m_rdata = 32'(m_active);
                else if (a == A_STAT) m_rdata = 32'(m_active) + 32'(m_pend_t) * 256 +
                                                (m_left > 0 ? 32'h1_0000 : 0) +
                                                (m_pend_v ? 32'h2_0000 : 0) + (m_err ? 32'h4_0000 : 0);
                else                  m_rdata = 32'(m_period);
            end
            host = acc && bus.wbs_we_i && a == A_CTRL && bus.wbs_sel_i[0];
            ok   = host && int'(d[7:0]) < N;
            if (host && !ok) m_err = 1;
            if (acc && bus.wbs_we_i && a == A_STAT && bus.wbs_sel_i[2] && d[18]) m_err = 0;
            rot = 0;
            if (m_left == 0 && m_period != 0) begin
                if (m_idle_cnt + 1 >= int'(m_period)) begin rot = 1; m_idle_cnt = 0; end
                else m_idle_cnt++;
            end
            if (acc && bus.wbs_we_i && a == A_PER) begin
                if (bus.wbs_sel_i[0]) m_period[7:0]   = d[7:0];
                if (bus.wbs_sel_i[1]) m_period[15:8]  = d[15:8];
                if (bus.wbs_sel_i[2]) m_period[23:16] = d[23:16];
            end
            if (m_left > 0) begin
                if (m_left == G + 1) m_active = m_target;
                m_left--;
                if (ok) begin m_pend_v = 1; m_pend_t = int'(d[7:0]); end
            end else begin
                tgt = -1;
                if (ok)            begin m_pend_v = 0; tgt = int'(d[7:0]); end
                else if (m_pend_v) begin m_pend_v = 0; tgt = m_pend_t; end
                else if (rot)      tgt = (m_active + 1) % N;
                if (tgt >= 0 && tgt != m_active) begin m_target = tgt; m_left = 2 * G + 1; end
            end
            m_ack = acc;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [2:0] exp_r;
            exp_r = 3'b111;
            if (!m_in_rst && m_left == 0) exp_r[m_active] = 1'b0;
            check("cyc active", 32'(active), 32'(m_active));
            check("cyc busy", 32'(busy), 32'(m_left > 0));
            check("cyc gate", 32'(gate), 32'(m_in_rst || m_left > 0));
            check("cyc reset_o", 32'(proj_rst), 32'(exp_r));
            check("cyc ack", 32'(bus.wbs_ack_o), 32'(m_ack));
            check("cyc dat_o", bus.wbs_dat_o, m_rdata);
        end
    end

    // Run-length monitors for busy/gate windows and idle gaps.
    int busy_run = 0, gate_run = 0, idle_run = 0, last_busy = 0, last_gate = 0, last_idle = 0;
    always @(negedge clk) begin
        if (busy) begin
            busy_run++;
            if (idle_run > 0) begin last_idle = idle_run; idle_run = 0; end
        end else begin
            idle_run++;
            if (busy_run > 0) begin last_busy = busy_run; busy_run = 0; end
        end
        if (gate) gate_run++;
        else if (gate_run > 0) begin last_gate = gate_run; gate_run = 0; end
    end

    task automatic wb_access(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, output logic [31:0] rd, output bit acked);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_sel_i = sel;  bus.wbs_dat_i = dat;
        acked = 1'b0;
        rd = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o === 1'b1) begin acked = 1'b1; rd = bus.wbs_dat_o; end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat, input string name);
        logic [31:0] rd;
        bit ok;
        wb_access(1'b1, adr, sel, dat, rd, ok);
        check({name, " ack"}, 32'(ok), 32'd1);
    endtask

    task automatic rd_chk(input logic [31:0] adr, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        bit ok;
        wb_access(1'b0, adr, 4'hf, 32'd0, rd, ok);
        check({name, " ack"}, 32'(ok), 32'd1);
        check(name, rd, exp);
    endtask

    task automatic wait_busy(input bit lvl, input int budget, input string name);
        int n = 0;
        while (busy !== lvl && n < budget) begin @(negedge clk); n++; end
        check({name, " wait"}, 32'(busy), 32'(lvl));
    endtask

    initial begin
        logic [31:0] rd;
        bit ok;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 0; bus.wbs_dat_i = 0; bus.wbs_adr_i = 0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst gate", 32'(gate), 32'd1);
        check("rst reset_o", 32'(proj_rst), 32'h7);
        check("rst busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rel active", 32'(active), 32'd0);
        check("rel reset_o", 32'(proj_rst), 32'h6);
        check("rel gate", 32'(gate), 32'd0);
        rd_chk(A_CTRL, 32'd0, "ctrl read0");

        // Single switch to project 1.
        wr(A_CTRL, 4'hf, 32'd1, "sw1");
        check("sw1 busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        check("sw1 active early", 32'(active), 32'd0);
        @(negedge clk);
        check("sw1 active", 32'(active), 32'd1);
        wait_busy(1'b0, 20, "sw1 done");
        @(negedge clk);
        check("sw1 busy len", 32'(last_busy), 32'd9);
        check("sw1 gate len", 32'(last_gate), 32'd9);
        check("sw1 reset_o", 32'(proj_rst), 32'h5);

        // Switch to 2 with a queued request back to 0.
        wr(A_CTRL, 4'hf, 32'd2, "sw2");
        wr(A_CTRL, 4'hf, 32'd0, "pend0");
        repeat (3) @(negedge clk);
        rd_chk(A_STAT, 32'h0003_0002, "stat pend");
        wait_busy(1'b0, 20, "sw2 done");
        check("sw2 active", 32'(active), 32'd2);
        wait_busy(1'b1, 5, "pend start");
        wait_busy(1'b0, 20, "pend done");
        @(negedge clk);
        check("pend active", 32'(active), 32'd0);
        check("pend reset_o", 32'(proj_rst), 32'h6);
        check("pend busy len", 32'(last_busy), 32'd9);
        rd_chk(A_STAT, 32'h0, "stat clean");

        // Out-of-range targets, error flag and its W1C clear.
        wr(A_CTRL, 4'hf, 32'd7, "bad7");
        repeat (2) @(negedge clk);
        check("bad7 busy", 32'(busy), 32'd0);
        rd_chk(A_STAT, 32'h0004_0000, "stat err");
        wr(A_STAT, 4'b1011, 32'h0004_0000, "w1c nosel");
        rd_chk(A_STAT, 32'h0004_0000, "stat err kept");
        wr(A_STAT, 4'b0100, 32'h0004_0000, "w1c");
        rd_chk(A_STAT, 32'h0, "stat err clr");
        wr(A_CTRL, 4'hf, 32'd3, "bad3");
        rd_chk(A_STAT, 32'h0004_0000, "stat err3");
        wr(A_STAT, 4'b0100, 32'h0004_0000, "w1c2");

        // Requests that must be acked but do nothing.
        wr(A_CTRL, 4'b1110, 32'd1, "sel0 low");
        wr(A_CTRL, 4'hf, 32'd0, "same tgt");
        repeat (2) @(negedge clk);
        check("noop busy", 32'(busy), 32'd0);
        rd_chk(A_CTRL, 32'd0, "ctrl noop");
        wb_access(1'b0, 32'h3000_0000, 4'hf, 32'd0, rd, ok);
        check("unmapped ack", 32'(ok), 32'd0);
`ifndef AUTO_ROTATE_EN
        wb_access(1'b0, A_PER, 4'hf, 32'd0, rd, ok);
        check("period absent ack", 32'(ok), 32'd0);
`endif

        // Reset during ISOLATE with a request pending.
        wr(A_CTRL, 4'hf, 32'd1, "rst sw");
        wr(A_CTRL, 4'hf, 32'd2, "rst pend");
        #2 rst_n = 1'b0;
        #1;
        check("mid rst gate", 32'(gate), 32'd1);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst reset_o", 32'(proj_rst), 32'h7);
        check("mid rst active", 32'(active), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post rst gate", 32'(gate), 32'd0);
        check("post rst reset_o", 32'(proj_rst), 32'h6);
        repeat (3) @(negedge clk);
        check("post rst busy", 32'(busy), 32'd0);
        rd_chk(A_STAT, 32'h0, "post rst stat");

`ifdef AUTO_ROTATE_EN
        wr(A_PER, 4'hf, 32'd20, "period");
        rd_chk(A_PER, 32'd20, "period read");
        for (int k = 1; k <= 3; k++) begin
            wait_busy(1'b1, 60, "rot start");
            wait_busy(1'b0, 30, "rot done");
            @(negedge clk);
            check("rot active", 32'(active), 32'(k % 3));
            if (k > 1) check("rot gap", 32'(last_idle), 32'd20);
        end
        wr(A_PER, 4'hf, 32'd0, "period off");
        repeat (30) @(negedge clk);
        check("rot stopped", 32'(busy), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/project_switch_ctrl.md
PROJECT_SWITCH_CTRL -- requirements
Module: project_switch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_CTRL, default 32'h30000010: control register address (target project select).
REQ-002 SHALL have parameter ADDR_STATUS, default 32'h30000014: status register address.
REQ-003 SHALL have parameter NUM_PROJECTS, default 3: number of selectable projects, range 1..255.
REQ-004 SHALL have parameter GUARD_CYCLES, default 16: isolate and reset-hold duration in cycles, range 1..255.
REQ-005 SHALL have port wb_clk_i, input, 1: the single clock.
REQ-006 SHALL have port wb_rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have Wishbone slave inputs wbs_stb_i (1), wbs_cyc_i (1), wbs_we_i (1), wbs_sel_i (4), wbs_dat_i (32) and wbs_adr_i (32).
REQ-008 SHALL have Wishbone slave outputs wbs_ack_o (1) and wbs_dat_o (32).
REQ-009 SHALL have port active_project_o, output, 8: index of the project driving the pads.
REQ-010 SHALL have port project_reset_o, output, NUM_PROJECTS: per-project reset, 1 = held in reset.
REQ-011 SHALL have port io_gate_o, output, 1: 1 = pad outputs forced to 0 and oeb forced high by the harness.
REQ-012 SHALL have port busy_o, output, 1: switch sequence in progress.

Function
REQ-013 SHALL treat an access as valid when cyc&stb are high, wbs_ack_o is low and the address matches a mapped register.
REQ-014 SHALL pulse wbs_ack_o for exactly one cycle, on the cycle after a valid access; unmapped addresses SHALL get no ack.
REQ-015 SHALL treat a CTRL write with sel[0]=1 as a switch request to target=wbs_dat_i[7:0]; sel[0]=0 SHALL be acked with no effect.
REQ-016 SHALL, for a target >= NUM_PROJECTS, ack the write, ignore the request and set sticky err.
REQ-017 SHALL, for a target equal to active_project_o while IDLE, ack the write and take no action.
REQ-018 SHALL run FSM IDLE->ISOLATE->SWITCH->HOLD->IDLE.
REQ-019 SHALL enter ISOLATE on the edge that asserts ack; in ISOLATE, io_gate_o=1 and all project_reset_o=1 for GUARD_CYCLES cycles.
REQ-020 SHALL, in SWITCH (1 cycle), load active_project_o from the target.
REQ-021 SHALL, in HOLD, keep io_gate_o=1 and all resets high for GUARD_CYCLES cycles, then enter IDLE.
REQ-022 SHALL keep busy_o high for exactly 2*GUARD_CYCLES+1 cycles per switch.
REQ-023 SHALL, in IDLE, drive io_gate_o=0 and project_reset_o all-ones except bit[active_project_o]=0.
REQ-024 SHALL store a valid CTRL write received while busy in a one-deep pending register (last write wins) and ack it normally.
REQ-025 SHALL, on return to IDLE with pending set and target != active, clear pending and start ISOLATE on the next cycle; if pending equals active, clear it with no switch.
REQ-026 SHALL return STATUS read data [7:0]=active, [15:8]=pending target, [16]=busy, [17]=pending valid, [18]=err, other bits 0.
REQ-027 SHALL clear err on a STATUS write with sel[2]=1 and dat[18]=1 (W1C); all other STATUS write bits SHALL be ignored.
REQ-028 SHALL return CTRL read data [7:0]=active, other bits 0.

Reset
REQ-029 SHALL, while wb_rst_n_i is low, force: state IDLE, active_project_o=0, project_reset_o all-ones, io_gate_o=1, busy_o=0, wbs_ack_o=0, wbs_dat_o=0, pending and err cleared, counters 0.
REQ-030 SHALL, on the first edge after release, behave as IDLE with project 0 (io_gate_o=0, bit0 reset low).
REQ-031 SHALL, on reset mid-sequence, abort the sequence and discard pending.

Configuration
REQ-032 SHALL, when AUTO_ROTATE_EN is defined, add register ADDR_CTRL+8 holding a 24-bit period (reset 0), readable and writable.
REQ-033 SHALL, with AUTO_ROTATE_EN defined and period nonzero, run a counter in IDLE and issue an internal request to (active+1) mod NUM_PROJECTS every period cycles; the counter SHALL hold in busy states.
REQ-034 SHALL give a host CTRL write priority over a rotation request in the same cycle.
REQ-035 SHALL, when AUTO_ROTATE_EN is undefined, not decode ADDR_CTRL+8 (no ack) and never rotate.

Verification (GUARD_CYCLES=4, NUM_PROJECTS=3)
REQ-036 SHALL cover: reset release -> active=0, reset_o=3'b110, gate=0; CTRL read returns 0.
REQ-037 SHALL cover: write CTRL=1 -> ack 1 cycle; busy high 9 cycles; gate high 9 cycles; active=1 after 5 cycles; final reset_o=3'b101.
REQ-038 SHALL cover: write CTRL=2 then CTRL=0 during busy -> STATUS shows pending 0, valid 1; a second switch to 0 follows; final active=0.
REQ-039 SHALL cover: write CTRL=7 -> acked, no busy, STATUS[18]=1; W1C write of 0x40000 -> STATUS[18]=0.
REQ-040 SHALL cover: wb_rst_n_i low during ISOLATE -> immediate gate=1, busy=0; after release active=0, no pending.
REQ-041 SHALL cover: with AUTO_ROTATE_EN and period=20 -> active sequence 0,1,2,0, with switches starting 20 IDLE cycles apart.
